// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle MIPS main controller: state encoding,
// opcodes, ALUOp and PC-source encodings.
package mc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_FETCH,
    S_DECODE,
    S_EXEC_R,
    S_EXEC_I,
    S_MEM_ADDR,
    S_MEM_RD,
    S_MEM_WR,
    S_WB_R,
    S_WB_I,
    S_WB_MEM,
    S_BRANCH,
    S_JUMP,
    S_ILLEGAL
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // Shared with the existing ALU control decoder; do not renumber.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_OR    = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;

  localparam logic [1:0] PC_SRC_SEQ    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  function automatic logic is_wait_state(input state_t s);
    return (s == S_FETCH) || (s == S_MEM_RD) || (s == S_MEM_WR);
  endfunction

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait counter: counts cycles spent in a memory state without mem_ready
// and flags the cycle that would exhaust the TIMEOUT budget.
module mc_wait_timer
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic waiting,
  input  logic mem_ready,
  output logic timeout
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] count_q, count_d;

  // The TIMEOUT-th unanswered cycle is the error cycle, so compare one short.
  assign timeout = waiting && !mem_ready && (count_q == CW'(TIMEOUT - 1));

  always_comb begin
    count_d = count_q + CW'(1);
    if (!waiting || mem_ready || timeout) count_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) count_q <= '0;
    else        count_q <= count_d;
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle main controller: sequences fetch/decode/execute/memory/writeback,
// decodes datapath controls from the current state and counts retirements.
module mc_control
  import mc_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic [2:0]       alu_op,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             illegal,
  output logic             bus_err,
  output logic [CNT_W-1:0] retired,
  output logic [3:0]       state
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             waiting, timeout, retire;

  assign waiting = is_wait_state(state_q);

  mc_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
    .clk       (clk),
    .rst_n     (rst_n),
    .waiting   (waiting),
    .mem_ready (mem_ready),
    .timeout   (timeout)
  );

  always_comb begin
    state_d    = state_q;
    retire     = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    i_or_d     = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = PC_SRC_SEQ;
    alu_op     = ALU_ADD;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    illegal    = 1'b0;
    bus_err    = 1'b0;
    case (state_q)
      S_IDLE: state_d = S_FETCH;
      S_FETCH: begin
        mem_read = 1'b1;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = S_DECODE;
        end else if (timeout) begin
          bus_err = 1'b1;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                         state_d = S_EXEC_R;
          OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
          OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: state_d = S_EXEC_I;
          OP_J:                             state_d = S_JUMP;
          default:                          state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        alu_op  = ALU_RTYPE;
        alu_src = 1'b1;
        state_d = S_WB_R;
      end
      S_EXEC_I: begin
        case (opcode)
          OP_SLTI: alu_op = ALU_SLT;
          OP_ANDI: alu_op = ALU_AND;
          OP_ORI:  alu_op = ALU_OR;
          default: alu_op = ALU_ADD;
        endcase
        state_d = S_WB_I;
      end
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) begin
          state_d = S_WB_MEM;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else if (timeout) begin
          bus_err = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WB_R: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_I: begin
        reg_write = 1'b1;
        retire    = 1'b1;
        state_d   = S_FETCH;
      end
      S_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        retire     = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_op   = ALU_SUB;
        alu_src  = 1'b1;
        pc_src   = PC_SRC_BRANCH;
        pc_write = (opcode == OP_BNE) ? !zero : zero;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        pc_src   = PC_SRC_JUMP;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_ILLEGAL: begin
        illegal = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign retired_d = retire ? retired_q + CNT_W'(1) : retired_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
    end
  end

  assign retired = retired_q;
  assign state   = state_q;

endmodule
